tm_class_argmax: RTL and testbench
==================================

TM_CLASS_ARGMAX -- requirements
Module: tm_class_argmax

Interface
REQ-001 SHALL have parameter CLASS_NUM, default 10, number of classes (>=1).
REQ-002 SHALL have parameter CLAUSE_NUM, default 100, clauses per class (even, >=2).
REQ-003 SHALL have parameter C_M00_AXIS_TDATA_WIDTH, default 64, output stream width (>= 16+SUM_W).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port clauses, input, [CLAUSE_NUM-1:0] x CLASS_NUM, clause outputs per class.
REQ-007 SHALL have port in_valid, input, 1, clause vector valid.
REQ-008 SHALL have port in_last, input, 1, final sample of frame.
REQ-009 SHALL have port in_ready, output, 1, block can accept a sample.
REQ-010 SHALL have ports m00_axis_tvalid (output, 1), m00_axis_tready (input, 1), m00_axis_tdata (output, C_M00_AXIS_TDATA_WIDTH) and m00_axis_tlast (output, 1) forming the result stream.

Function
REQ-011 SHALL define SUM_W = $clog2(CLAUSE_NUM/2+1)+1 and CLASS_W = max(1,$clog2(CLASS_NUM)).
REQ-012 SHALL compute each class sum as signed popcount(even-index clauses) minus popcount(odd-index clauses), in SUM_W bits, with no overflow possible.
REQ-013 SHALL implement FSM states IDLE, SUM and OUT.
REQ-014 SHALL hold in_ready=1 only in IDLE.
REQ-015 SHALL, on in_valid&&in_ready at edge T, register all clauses and in_last and enter SUM.
REQ-016 SHALL evaluate class k at edge T+1+k, for k=0..CLASS_NUM-1, one class per cycle.
REQ-017 SHALL keep a running maximum with strict greater-than comparison, so ties resolve to the lowest index.
REQ-018 SHALL, after class CLASS_NUM-1, enter OUT with m00_axis_tvalid=1 from cycle T+CLASS_NUM+1.
REQ-019 SHALL drive m00_axis_tdata[CLASS_W-1:0]=winning index and [16+SUM_W-1:16]=winning sum (sign-extended to bit 31), with all other bits 0.
REQ-020 SHALL drive m00_axis_tlast equal to the registered in_last.
REQ-021 SHALL hold tdata, tlast and tvalid stable in OUT until m00_axis_tready=1.
REQ-022 SHALL return to IDLE on the OUT handshake edge, so in_ready=1 on the next cycle; the block accepts no input in the same cycle as the output handshake.
REQ-023 SHALL ignore in_valid outside IDLE; input changes during SUM or OUT SHALL NOT affect the result.
REQ-024 SHALL, when CLASS_NUM=1, output index 0 after exactly one SUM cycle.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, force state IDLE, in_ready=1, m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, running max/index=0, class counter=0.
REQ-026 SHALL, on reset asserted during SUM or OUT, discard the in-flight sample and emit no output for it.
REQ-027 SHALL take reset priority over every handshake in the same cycle.

Configuration
REQ-028 SHALL, with TM_CLASS_SUMS_EN defined, add output port class_sums (signed [SUM_W-1:0] x CLASS_NUM), where entry k is registered at evaluation of class k, is held through OUT, and resets to 0.
REQ-029 SHALL, without TM_CLASS_SUMS_EN, have no class_sums port or storage, with all other behaviour identical.

Structure
REQ-030 SHALL put the state enum typedef and the SUM_W/CLASS_W helper functions in shared package tm_pkg.
REQ-031 SHALL use one combinational sub-module, tm_clause_popcount (CLAUSE_NUM in, signed SUM_W out), instantiated once and muxed by the class counter.

Verification
REQ-032 SHALL verify basic flow: CLASS_NUM=10, CLAUSE_NUM=100, class 3 with all even clauses =1 and all others 0 -> one cycle after T+10, tvalid=1 with index 3 and sum +50.
REQ-033 SHALL verify ties: classes 2 and 7 both sum +5, all others negative -> index 2.
REQ-034 SHALL verify all-zero input: all clauses 0 -> index 0, sum 0; with a negative-only class 0 of -50 and all others -50 -> index 0.
REQ-035 SHALL verify backpressure: tready held low 20 cycles -> tdata/tlast stable and in_ready=0 throughout; the handshake is followed by in_ready=1 one cycle later.
REQ-036 SHALL verify last: three samples with in_last=1 on the third -> tlast=1 only on the third result.
REQ-037 SHALL verify reset mid-operation: rst at T+4 -> tvalid never asserts for that sample; the next sample produces a correct result.

Source files
------------

// File: rtl/tm_pkg.sv
// Shared types and width helpers for the Tsetlin-machine class argmax block.
package tm_pkg;

   // Controller states: wait for a sample, sweep the classes, present the result.
   typedef enum logic [1:0] {
      StIdle,
      StSum,
      StOut
   } state_e;

   // Width of a signed class sum: holds -CLAUSE_NUM/2 .. +CLAUSE_NUM/2.
   function automatic int sum_w(input int clause_num);
      return $clog2(clause_num / 2 + 1) + 1;
   endfunction

   // Width of a class index; never narrower than one bit.
   function automatic int class_w(input int class_num);
      return (class_num > 1) ? $clog2(class_num) : 1;
   endfunction

endpackage

// File: rtl/tm_clause_popcount.sv
// Combinational class sum: popcount of even-index clauses minus popcount of odd-index clauses.
module tm_clause_popcount
   import tm_pkg::*;
#(
   parameter int CLAUSE_NUM = 100,
   localparam int SUM_W = sum_w(CLAUSE_NUM)
) (
   input  logic [CLAUSE_NUM-1:0]   clauses,
   output logic signed [SUM_W-1:0] sum
);

   // Each count fits in SUM_W-1 bits, so the difference cannot overflow SUM_W.
   logic [SUM_W-1:0] pos;
   logic [SUM_W-1:0] neg;

   // Count positive- and negative-polarity clause votes.
   always_comb begin
      pos = '0;
      neg = '0;
      for (int i = 0; i < CLAUSE_NUM; i++) begin
         if (i % 2 == 0) begin
            pos = pos + SUM_W'(clauses[i]);
         end else begin
            neg = neg + SUM_W'(clauses[i]);
         end
      end
      sum = signed'(pos - neg);
   end

endmodule

// File: rtl/tm_class_argmax.sv
// Tsetlin-machine class argmax: registers one clause vector, evaluates one class per cycle
// through a shared popcount, and streams out the winning index and sum.
// Optional build macro TM_CLASS_SUMS_EN adds the class_sums port with every per-class sum.
module tm_class_argmax
   import tm_pkg::*;
#(
   parameter int CLASS_NUM              = 10,
   parameter int CLAUSE_NUM             = 100,
   parameter int C_M00_AXIS_TDATA_WIDTH = 64,
   localparam int SUM_W   = sum_w(CLAUSE_NUM),
   localparam int CLASS_W = class_w(CLASS_NUM)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [CLASS_NUM-1:0][CLAUSE_NUM-1:0]   clauses,
   input  logic                                   in_valid,
   input  logic                                   in_last,
   output logic                                   in_ready,
   output logic                                   m00_axis_tvalid,
   input  logic                                   m00_axis_tready,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]      m00_axis_tdata,
   output logic                                   m00_axis_tlast
`ifdef TM_CLASS_SUMS_EN
   ,
   output logic signed [CLASS_NUM-1:0][SUM_W-1:0] class_sums
`endif
);

   state_e                                state_q;
   state_e                                state_d;
   logic [CLASS_NUM-1:0][CLAUSE_NUM-1:0]  clauses_q;
   logic                                  last_q;
   logic [CLASS_W-1:0]                    cnt_q;
   logic [CLASS_W-1:0]                    idx_q;
   logic signed [SUM_W-1:0]               max_q;
   logic signed [SUM_W-1:0]               cur_sum;
   logic [CLAUSE_NUM-1:0]                 sel_clauses;
   logic                                  last_class;

   assign last_class = (cnt_q == CLASS_W'(CLASS_NUM - 1));

   // Select the clause vector of the class under evaluation.
   always_comb begin
      sel_clauses = '0;
      for (int k = 0; k < CLASS_NUM; k++) begin
         if (cnt_q == CLASS_W'(k)) begin
            sel_clauses = clauses_q[k];
         end
      end
   end

   tm_clause_popcount #(
      .CLAUSE_NUM (CLAUSE_NUM)
   ) u_popcount (
      .clauses (sel_clauses),
      .sum     (cur_sum)
   );

   // State register; reset wins over any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_d         = state_q;
      in_ready        = 1'b0;
      m00_axis_tvalid = 1'b0;
      case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = StSum;
            end
         end
         StSum: begin
            if (last_class) begin
               state_d = StOut;
            end
         end
         StOut: begin
            m00_axis_tvalid = 1'b1;
            if (m00_axis_tready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Sample capture and running maximum; class 0 always seeds the maximum so that a
   // stale result from the previous sample never survives.
   always_ff @(posedge clk) begin
      if (rst) begin
         clauses_q <= '0;
         last_q    <= 1'b0;
         cnt_q     <= '0;
         idx_q     <= '0;
         max_q     <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  clauses_q <= clauses;
                  last_q    <= in_last;
                  cnt_q     <= '0;
               end
            end
            StSum: begin
               cnt_q <= last_class ? '0 : cnt_q + CLASS_W'(1);
               // Strict compare keeps the lowest index on ties.
               if ((cnt_q == '0) || (cur_sum > max_q)) begin
                  max_q <= cur_sum;
                  idx_q <= cnt_q;
               end
            end
            default: ;
         endcase
      end
   end

   // Result word: index in the low bits, sign-extended sum from bit 16 up to bit 31.
   always_comb begin
      m00_axis_tdata                = '0;
      m00_axis_tdata[CLASS_W-1:0]   = idx_q;
      m00_axis_tdata[16 +: SUM_W]   = max_q;
      for (int b = 16 + SUM_W; (b < 32) && (b < C_M00_AXIS_TDATA_WIDTH); b++) begin
         m00_axis_tdata[b] = max_q[SUM_W-1];
      end
   end

   assign m00_axis_tlast = last_q;

`ifdef TM_CLASS_SUMS_EN
   logic signed [CLASS_NUM-1:0][SUM_W-1:0] sums_q;

   // Capture each class sum as it is evaluated; held until the next sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         sums_q <= '0;
      end else if (state_q == StSum) begin
         for (int k = 0; k < CLASS_NUM; k++) begin
            if (cnt_q == CLASS_W'(k)) begin
               sums_q[k] <= cur_sum;
            end
         end
      end
   end

   assign class_sums = sums_q;
`endif

endmodule

// File: tb/tb_tm_class_argmax.sv
// Directed bench for tm_class_argmax with hand-computed expected results.
module tb_tm_class_argmax;

   localparam int CN = 10;
   localparam int KN = 100;
   localparam int W  = 64;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [CN-1:0][KN-1:0]   clauses;
   logic [CN-1:0][KN-1:0]   cl;
   logic                    in_valid;
   logic                    in_last;
   logic                    in_ready;
   logic                    tvalid;
   logic                    tready;
   logic [W-1:0]            tdata;
   logic                    tlast;
   int                      checks = 0;
   int                      failures = 0;
   int                      seen;

   always #5 clk = ~clk;

   tm_class_argmax #(
      .CLASS_NUM              (CN),
      .CLAUSE_NUM             (KN),
      .C_M00_AXIS_TDATA_WIDTH (W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .clauses         (clauses),
      .in_valid        (in_valid),
      .in_last         (in_last),
      .in_ready        (in_ready),
      .m00_axis_tvalid (tvalid),
      .m00_axis_tready (tready),
      .m00_axis_tdata  (tdata),
      .m00_axis_tlast  (tlast)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // p even-index (positive) clauses and n odd-index (negative) clauses set.
   function automatic logic [KN-1:0] mk(input int p, input int n);
      logic [KN-1:0] v;
      v = '0;
      for (int i = 0; i < p; i++) v[2*i] = 1'b1;
      for (int i = 0; i < n; i++) v[2*i+1] = 1'b1;
      return v;
   endfunction

   task automatic scramble();
      logic [127:0] r;
      for (int k = 0; k < CN; k++) begin
         r = {$urandom, $urandom, $urandom, $urandom};
         clauses[k] = r[KN-1:0];
      end
   endtask

   task automatic run_sample(input logic [CN-1:0][KN-1:0] smp, input logic last,
                             input int exp_idx, input int exp_sum, input int hold,
                             input string tag);
      logic [63:0] e;
      e        = '0;
      e[3:0]   = exp_idx[3:0];
      e[31:16] = exp_sum[15:0];
      @(negedge clk);
      check_eq({tag, ":ready"}, in_ready, 1);
      clauses  = smp;
      in_last  = last;
      in_valid = 1'b1;
      @(negedge clk);
      check_eq({tag, ":busy"}, in_ready, 0);
      // Inputs keep changing and in_valid stays high while the sample is in flight.
      scramble();
      in_last = ~last;
      repeat (CN - 1) @(negedge clk);
      check_eq({tag, ":early"}, tvalid, 0);
      @(negedge clk);
      check_eq({tag, ":valid"}, tvalid, 1);
      check_eq({tag, ":data"}, tdata, e);
      check_eq({tag, ":last"}, tlast, last);
      for (int h = 0; h < hold; h++) begin
         scramble();
         @(negedge clk);
         check_eq({tag, ":hold_data"}, tdata, e);
         check_eq({tag, ":hold_last"}, tlast, last);
         check_eq({tag, ":hold_valid"}, tvalid, 1);
         check_eq({tag, ":hold_ready"}, in_ready, 0);
      end
      in_valid = 1'b0;
      tready   = 1'b1;
      @(negedge clk);
      tready = 1'b0;
      check_eq({tag, ":done_valid"}, tvalid, 0);
      check_eq({tag, ":done_ready"}, in_ready, 1);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      tready   = 1'b0;
      clauses  = '0;
      repeat (3) @(negedge clk);
      check_eq("rst:in_ready", in_ready, 1);
      check_eq("rst:tvalid", tvalid, 0);
      check_eq("rst:tdata", tdata, 0);
      check_eq("rst:tlast", tlast, 0);
      rst = 1'b0;

      // Class 3 has all 50 positive clauses.
      cl = '0;
      cl[3] = mk(50, 0);
      run_sample(cl, 1'b0, 3, 50, 0, "basic");

      // Classes 2 and 7 tie at +5, others at -3.
      for (int k = 0; k < CN; k++) cl[k] = mk(0, 3);
      cl[2] = mk(5, 0);
      cl[7] = mk(5, 0);
      run_sample(cl, 1'b0, 2, 5, 0, "tie");

      cl = '0;
      run_sample(cl, 1'b0, 0, 0, 0, "zero");

      for (int k = 0; k < CN; k++) cl[k] = mk(0, 50);
      run_sample(cl, 1'b0, 0, -50, 0, "neg");

      // Backpressure: class 9 = 10 - 2 = +8.
      cl = '0;
      cl[9] = mk(10, 2);
      run_sample(cl, 1'b1, 9, 8, 20, "bp");

      // Three-sample frame, last only on the third.
      cl = '0;
      cl[5] = mk(1, 0);
      run_sample(cl, 1'b0, 5, 1, 0, "frm0");
      cl = '0;
      cl[0] = mk(3, 1);
      cl[1] = mk(4, 1);
      run_sample(cl, 1'b0, 1, 3, 0, "frm1");
      for (int k = 0; k < CN; k++) cl[k] = mk(48, 0);
      cl[8] = mk(49, 0);
      run_sample(cl, 1'b1, 8, 49, 0, "frm2");

      // Reset at edge T+4 aborts the sample.
      cl = '0;
      cl[6] = mk(50, 0);
      @(negedge clk);
      clauses  = cl;
      in_last  = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("rstmid:in_ready", in_ready, 1);
      check_eq("rstmid:tvalid", tvalid, 0);
      check_eq("rstmid:tdata", tdata, 0);
      check_eq("rstmid:tlast", tlast, 0);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (tvalid) seen++;
      end
      check_eq("rstmid:no_out", seen, 0);

      cl = '0;
      cl[4] = mk(20, 0);
      run_sample(cl, 1'b0, 4, 20, 0, "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
